// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and Out field layout.
// No logic of its own; latency and backpressure are defined by the users of this package.
// Out packs {quotient, remainder}, so the quotient field starts at bit WIDTH.
package divider_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_CALC = CALC,
        ST_FIX  = FIX,
        ST_DONE = DONE
    } state_t;

    localparam int REM_LSB = 0;

    function automatic int quo_lsb(input int width);
        return width;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff_low;
    logic             borrow_low;

    // A set top bit means the shifted value is >= 2^WIDTH, which always exceeds
    // the divisor; the low WIDTH bits of the difference are then still exact.
    always_comb begin
        shifted                = {rem_i, dvd_bit_i};
        {borrow_low, diff_low} = {1'b0, shifted[WIDTH-1:0]} - {1'b0, dvs_i};
        q_o                    = shifted[WIDTH] | ~borrow_low;
        rem_o                  = q_o ? diff_low : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider with Start/Busy/Done handshake and divide-by-zero flag.
// Latency: Done WIDTH+2 cycles after the Start cycle, or 1 cycle when B is zero.
// Backpressure: Start is only taken in IDLE; requests while Busy or during Done are dropped.
module seq_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy,
    output logic               Done,
    output logic               DivByZero,
    output logic [2*WIDTH-1:0] Out
);

    localparam int QUO_LSB = quo_lsb(WIDTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               sgn_q, sgn_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               dbz_q, dbz_d;
    logic [2*WIDTH-1:0] out_q, out_d;

    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        a_mag   = (Signed && A[WIDTH-1]) ? -A : A;
        b_mag   = (Signed && B[WIDTH-1]) ? -B : B;
        quo_fix = (sgn_q && (sa_q ^ sb_q)) ? -dvd_q : dvd_q;
        rem_fix = (sgn_q && sa_q) ? -rem_q : rem_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        sgn_d   = sgn_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dbz_d   = dbz_q;
        out_d   = out_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    sgn_d = Signed;
                    sa_d  = A[WIDTH-1];
                    sb_d  = B[WIDTH-1];
                    dvd_d = a_mag;
                    dvs_d = b_mag;
                    rem_d = '0;
                    cnt_d = CNT_W'(WIDTH);
                    dbz_d = 1'b0;
                    if (B == '0) begin
                        dbz_d                    = 1'b1;
                        out_d[QUO_LSB +: WIDTH]  = '1;
                        out_d[REM_LSB +: WIDTH]  = A;
                        state_d                  = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                // Quotient bits shift into the dividend register as its bits are consumed.
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                out_d[QUO_LSB +: WIDTH] = quo_fix;
                out_d[REM_LSB +: WIDTH] = rem_fix;
                state_d                 = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            sgn_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dbz_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            sgn_q   <= sgn_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dbz_q   <= dbz_d;
            out_q   <= out_d;
        end
    end

    assign Busy      = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign Done      = (state_q == ST_DONE);
    assign DivByZero = dbz_q;
    assign Out       = out_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=32 and WIDTH=8.
module tb_seq_divider;

    logic        clk;
    logic        rst;

    logic        start32, sgn32, busy32, done32, dbz32;
    logic [31:0] a32, b32;
    logic [63:0] out32;

    logic        start8, sgn8, busy8, done8, dbz8;
    logic [7:0]  a8, b8;
    logic [15:0] out8;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic       s;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } vec8_t;

    seq_divider #(.WIDTH(32)) dut32 (
        .Clk(clk), .Reset(rst), .Start(start32), .Signed(sgn32), .A(a32), .B(b32),
        .Busy(busy32), .Done(done32), .DivByZero(dbz32), .Out(out32)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(rst), .Start(start8), .Signed(sgn8), .A(a8), .B(b8),
        .Busy(busy8), .Done(done8), .DivByZero(dbz8), .Out(out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request, counts edges (the sampling edge is 1) until Done, then steps into IDLE.
    task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] o, output logic z);
        sgn32 = s; a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = 1;
        while (done32 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        o = out32;
        z = dbz32;
        @(posedge clk); #1;
    endtask

    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [15:0] o, output logic z);
        sgn8 = s; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 1;
        while (done8 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        o = out8;
        z = dbz8;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy32, done32, dbz32} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags32: got %b expected 000", {busy32, done32, dbz32});
        end
        vectors++;
        if (out32 !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_out32: got %h expected 0", out32);
        end
        vectors++;
        if ({busy8, done8, dbz8, out8} !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_w8: got %h expected 0", {busy8, done8, dbz8, out8});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int lat; logic [63:0] o; logic z;
        run32(1'b0, 32'h00054123, 32'h0000547B, lat, o, z);
        vectors++;
        if (lat !== 34) begin
            miscompares++;
            $display("FAIL udiv_latency: got %0d expected 34", lat);
        end
        vectors++;
        if (o !== {32'h0000000F, 32'h00004DEE}) begin
            miscompares++;
            $display("FAIL udiv_out: got %h expected %h", o, {32'h0000000F, 32'h00004DEE});
        end
        vectors++;
        if (z !== 1'b0) begin
            miscompares++;
            $display("FAIL udiv_dbz: got %b expected 0", z);
        end
        run32(1'b0, 32'hFFFFFFFF, 32'h00000001, lat, o, z);
        vectors++;
        if (o !== {32'hFFFFFFFF, 32'h00000000}) begin
            miscompares++;
            $display("FAIL udiv_max_by_one: got %h expected %h", o, {32'hFFFFFFFF, 32'h0});
        end
    endtask

    task automatic test_signed();
        int lat; logic [63:0] o; logic z;
        run32(1'b0, 32'hFFFFFFF9, 32'h00000002, lat, o, z);
        vectors++;
        if (o !== {32'h7FFFFFFC, 32'h00000001}) begin
            miscompares++;
            $display("FAIL neg7_unsigned: got %h expected %h", o, {32'h7FFFFFFC, 32'h00000001});
        end
        run32(1'b1, 32'h00000007, 32'hFFFFFFFE, lat, o, z);
        vectors++;
        if (o !== {32'hFFFFFFFD, 32'h00000001}) begin
            miscompares++;
            $display("FAIL pos7_div_neg2: got %h expected %h", o, {32'hFFFFFFFD, 32'h00000001});
        end
        run32(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, o, z);
        vectors++;
        if (o !== {32'h80000000, 32'h00000000} || z !== 1'b0) begin
            miscompares++;
            $display("FAIL signed_overflow: got %h dbz %b expected %h dbz 0", o, z, {32'h80000000, 32'h0});
        end
        vectors++;
        if (lat !== 34) begin
            miscompares++;
            $display("FAIL signed_latency: got %0d expected 34", lat);
        end
    endtask

    task automatic test_divzero();
        int lat; logic [63:0] o; logic z;
        run32(1'b0, 32'h12345678, 32'h00000000, lat, o, z);
        vectors++;
        if (lat !== 1) begin
            miscompares++;
            $display("FAIL dbz_latency: got %0d expected 1", lat);
        end
        vectors++;
        if (o !== {32'hFFFFFFFF, 32'h12345678} || z !== 1'b1) begin
            miscompares++;
            $display("FAIL dbz_result: got %h dbz %b expected %h dbz 1", o, z, {32'hFFFFFFFF, 32'h12345678});
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (dbz32 !== 1'b1 || out32 !== {32'hFFFFFFFF, 32'h12345678}) begin
            miscompares++;
            $display("FAIL dbz_hold: got %h dbz %b expected held result", out32, dbz32);
        end
        run32(1'b1, 32'h80000000, 32'h00000000, lat, o, z);
        vectors++;
        if (o !== {32'hFFFFFFFF, 32'h80000000} || z !== 1'b1) begin
            miscompares++;
            $display("FAIL dbz_signed: got %h dbz %b expected %h dbz 1", o, z, {32'hFFFFFFFF, 32'h80000000});
        end
        run32(1'b1, 32'hFFFFFFF9, 32'h00000002, lat, o, z);
        vectors++;
        if (z !== 1'b0) begin
            miscompares++;
            $display("FAIL dbz_clear: got %b expected 0", z);
        end
        vectors++;
        if (o !== {32'hFFFFFFFD, 32'hFFFFFFFF}) begin
            miscompares++;
            $display("FAIL neg7_signed: got %h expected %h", o, {32'hFFFFFFFD, 32'hFFFFFFFF});
        end
    endtask

    // Entered with Out holding the signed -7/2 result from the previous scenario.
    task automatic test_abort();
        int lat; int nd; logic [63:0] o; logic z;
        sgn32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        start32 = 1'b1; a32 = 32'd555; b32 = 32'd3;
        @(posedge clk); #1;
        start32 = 1'b0;
        vectors++;
        if (busy32 !== 1'b1 || out32 !== {32'hFFFFFFFD, 32'hFFFFFFFF}) begin
            miscompares++;
            $display("FAIL busy_ignore: got busy %b out %h expected busy 1 out unchanged", busy32, out32);
        end
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({busy32, done32, dbz32} !== 3'b000 || out32 !== 64'h0) begin
            miscompares++;
            $display("FAIL midop_reset: got flags %b out %h expected 000 and 0", {busy32, done32, dbz32}, out32);
        end
        nd = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32 === 1'b1) nd++;
        end
        vectors++;
        if (nd !== 0) begin
            miscompares++;
            $display("FAIL no_done_after_reset: got %0d pulses expected 0", nd);
        end
        run32(1'b0, 32'd100, 32'd7, lat, o, z);
        vectors++;
        if (lat !== 34 || o !== {32'h0000000E, 32'h00000002}) begin
            miscompares++;
            $display("FAIL restart_100_7: got lat %0d out %h expected lat 34 out %h", lat, o, {32'hE, 32'h2});
        end
    endtask

    task automatic test_start_on_done();
        int lat; logic [63:0] o; logic z;
        sgn32 = 1'b0; a32 = 32'd1000; b32 = 32'd10; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = 1;
        while (done32 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (lat !== 34 || out32 !== {32'd100, 32'd0}) begin
            miscompares++;
            $display("FAIL div_1000_10: got lat %0d out %h expected lat 34 out %h", lat, out32, {32'd100, 32'd0});
        end
        start32 = 1'b1; a32 = 32'd9; b32 = 32'd3;
        @(posedge clk); #1;
        start32 = 1'b0;
        vectors++;
        if (busy32 !== 1'b0 || out32 !== {32'd100, 32'd0}) begin
            miscompares++;
            $display("FAIL start_on_done: got busy %b out %h expected busy 0 out unchanged", busy32, out32);
        end
        run32(1'b0, 32'd9, 32'd3, lat, o, z);
        vectors++;
        if (lat !== 34 || o !== {32'd3, 32'd0}) begin
            miscompares++;
            $display("FAIL start_after_done: got lat %0d out %h expected lat 34 out %h", lat, o, {32'd3, 32'd0});
        end
    endtask

    task automatic test_back_to_back_w8();
        vec8_t v [7];
        int lat; logic [15:0] o; logic z;
        v = '{
            '{1'b0, 8'd200, 8'd7,  8'd28, 8'd4,  1'b0},
            '{1'b0, 8'd255, 8'd16, 8'd15, 8'd15, 1'b0},
            '{1'b1, 8'h9C,  8'd7,  8'hF2, 8'hFE, 1'b0},
            '{1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0},
            '{1'b0, 8'd13,  8'd0,  8'hFF, 8'h0D, 1'b1},
            '{1'b0, 8'd7,   8'd9,  8'd0,  8'd7,  1'b0},
            '{1'b1, 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0}
        };
        for (int i = 0; i < 7; i++) begin
            run8(v[i].s, v[i].a, v[i].b, lat, o, z);
            vectors++;
            if (lat !== (v[i].z ? 1 : 10)) begin
                miscompares++;
                $display("FAIL w8_latency[%0d]: got %0d expected %0d", i, lat, v[i].z ? 1 : 10);
            end
            vectors++;
            if (o !== {v[i].q, v[i].r}) begin
                miscompares++;
                $display("FAIL w8_out[%0d]: got %h expected %h", i, o, {v[i].q, v[i].r});
            end
            vectors++;
            if (z !== v[i].z) begin
                miscompares++;
                $display("FAIL w8_dbz[%0d]: got %b expected %b", i, z, v[i].z);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
        start8 = 1'b0;  sgn8 = 1'b0;  a8 = '0;  b8 = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_abort();
        test_start_on_done();
        test_back_to_back_w8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
